// File: rtl/fp_norm_pack.sv
// fp_norm_pack: post-add normalize-and-pack stage for the half-precision adder.
//
// Takes the raw adder result (sign, biased exponent of the larger operand,
// unnormalized mantissa carry+hidden+fraction) and produces a packed result
// {exponent, fraction, sign} with overflow/underflow flags. Left normalization
// runs one bit per cycle; a carry is resolved by a single right shift.
//
// Build option: define FPNORM_ROUND_EN to round the carry right-shift to
// nearest-even using the shifted-out guard bit; otherwise that bit truncates.
//
// Ports:
//   clkk, rst      clock, asynchronous active-high reset
//   in_valid/ready upstream handshake (ready only while idle)
//   in_sign        result sign
//   in_exp         biased exponent (0 treated as 1, no hidden bit)
//   in_mant        {carry, hidden, fraction}
//   in_nan/in_inf  special-operand flags from upstream
//   out_valid/ready downstream handshake
//   out_res        {exponent, fraction, sign}
//   out_overflow   result saturated to Inf
//   out_underflow  result is subnormal
module fp_norm_pack #(
  parameter int unsigned EXP_W = 5,
  parameter int unsigned MAN_W = 10
) (
  input  logic                   clkk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_sign,
  input  logic [EXP_W-1:0]       in_exp,
  input  logic [MAN_W+1:0]       in_mant,
  input  logic                   in_nan,
  input  logic                   in_inf,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_res,
  output logic                   out_overflow,
  output logic                   out_underflow
);

  localparam int unsigned MW = MAN_W + 2;
  localparam int unsigned XW = EXP_W + 1;
  localparam logic [XW-1:0] EXP_MAX = XW'((1 << EXP_W) - 1);

  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

  state_t            state;
  logic              sign_q;
  logic [XW-1:0]     exp_q;
  logic [MW-1:0]     mant_q;
  logic              nan_q;
  logic              inf_q;

  logic [MAN_W-1:0]  rs_frac;
  logic [XW-1:0]     rs_exp;
  logic              rs_ovf;

  // Carry path: fraction and exponent after the one-bit right shift.
  // After the shift the hidden bit is the old carry, so the new fraction is
  // mant_q[MAN_W:1] and the guard bit is mant_q[0].
  always_comb begin
    rs_frac = mant_q[MAN_W:1];
    rs_exp  = exp_q + XW'(1);
`ifdef FPNORM_ROUND_EN
    if (mant_q[0] && mant_q[1]) begin
      rs_frac = mant_q[MAN_W:1] + MAN_W'(1);
      // All-ones significand rounds up to 2.0: fraction wraps to zero and
      // the extra right shift becomes one more exponent step.
      if (&mant_q[MAN_W:1]) begin
        rs_exp = exp_q + XW'(2);
      end
    end
`endif
    rs_ovf = (rs_exp >= EXP_MAX);
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clkk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      in_ready      <= 1'b1;
      out_valid     <= 1'b0;
      out_res       <= '0;
      out_overflow  <= 1'b0;
      out_underflow <= 1'b0;
      sign_q        <= 1'b0;
      exp_q         <= '0;
      mant_q        <= '0;
      nan_q         <= 1'b0;
      inf_q         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            sign_q   <= in_sign;
            exp_q    <= (in_exp == '0) ? XW'(1) : XW'(in_exp);
            mant_q   <= in_mant;
            nan_q    <= in_nan;
            inf_q    <= in_inf;
            in_ready <= 1'b0;
            state    <= NORM;
          end
        end

        NORM: begin
          // Every outcome except a left shift packs and presents the result.
          state     <= DONE;
          out_valid <= 1'b1;
          if (nan_q) begin
            out_res <= {{EXP_W{1'b1}}, {MAN_W{1'b1}}, 1'b0};
          end else if (inf_q) begin
            out_res <= {{EXP_W{1'b1}}, {MAN_W{1'b0}}, sign_q};
          end else if (mant_q == '0) begin
            out_res <= '0;
          end else if (mant_q[MW-1]) begin
            if (rs_ovf) begin
              out_res      <= {{EXP_W{1'b1}}, {MAN_W{1'b0}}, sign_q};
              out_overflow <= 1'b1;
            end else begin
              out_res <= {rs_exp[EXP_W-1:0], rs_frac, sign_q};
            end
          end else if (mant_q[MAN_W]) begin
            out_res <= {exp_q[EXP_W-1:0], mant_q[MAN_W-1:0], sign_q};
          end else if (exp_q > XW'(1)) begin
            mant_q    <= mant_q << 1;
            exp_q     <= exp_q - XW'(1);
            state     <= NORM;
            out_valid <= 1'b0;
          end else begin
            out_res       <= {{EXP_W{1'b0}}, mant_q[MAN_W-1:0], sign_q};
            out_underflow <= 1'b1;
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid     <= 1'b0;
            out_overflow  <= 1'b0;
            out_underflow <= 1'b0;
            in_ready      <= 1'b1;
            state         <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_norm_pack.sv
// Testbench for fp_norm_pack: directed vectors, randomized items against an
// arithmetic reference model, backpressure hold and reset mid-operation.
module tb_fp_norm_pack;

  logic        clkk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [4:0]  in_exp;
  logic [11:0] in_mant;
  logic        in_nan;
  logic        in_inf;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_res;
  logic        out_overflow;
  logic        out_underflow;

  int checks = 0;
  int errors = 0;

  fp_norm_pack dut (
    .clkk          (clkk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_sign       (in_sign),
    .in_exp        (in_exp),
    .in_mant       (in_mant),
    .in_nan        (in_nan),
    .in_inf        (in_inf),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_res       (out_res),
    .out_overflow  (out_overflow),
    .out_underflow (out_underflow)
  );

  initial clkk = 1'b0;
  always #5 clkk = ~clkk;

`ifdef FPNORM_ROUND_EN
  localparam logic [15:0] R_C03 = 16'h8404;
  localparam logic [15:0] R_FFF = 16'h8800;
  localparam logic [15:0] R_E29 = 16'hF800;
  localparam logic        O_E29 = 1'b1;
`else
  localparam logic [15:0] R_C03 = 16'h8402;
  localparam logic [15:0] R_FFF = 16'h87FE;
  localparam logic [15:0] R_E29 = 16'hF7FE;
  localparam logic        O_E29 = 1'b0;
`endif

  typedef struct {
    logic        s;
    logic [4:0]  e;
    logic [11:0] m;
    logic        n;
    logic        i;
    logic [15:0] r;
    logic        ov;
    logic        un;
    int          lat;
  } vec_t;

  // Reference: value-level normalization with integer arithmetic.
  function automatic void model(input logic s, input int e_in, input int m_in,
                                input logic n, input logic i,
                                output logic [15:0] res, output logic ovf,
                                output logic unf, output int lat);
    int e;
    int m;
    int k;
    int g;
    e = (e_in == 0) ? 1 : e_in;
    m = m_in;
    k = 0;
    ovf = 1'b0;
    unf = 1'b0;
    if (n) begin
      res = 16'hFFFE;
    end else if (i) begin
      res = 16'(31 * 2048 + int'(s));
    end else if (m == 0) begin
      res = 16'h0000;
    end else if (m >= 2048) begin
      g = m % 2;
      m = m / 2;
      e = e + 1;
`ifdef FPNORM_ROUND_EN
      if (g == 1 && (m % 2) == 1) begin
        m = m + 1;
        if (m >= 2048) begin
          m = m / 2;
          e = e + 1;
        end
      end
`else
      g = 0;
`endif
      if (e >= 31) begin
        res = 16'(31 * 2048 + int'(s));
        ovf = 1'b1;
      end else begin
        res = 16'(e * 2048 + (m % 1024) * 2 + int'(s));
      end
    end else begin
      while (m < 1024 && e > 1) begin
        m = m * 2;
        e = e - 1;
        k = k + 1;
      end
      if (m < 1024) begin
        unf = 1'b1;
        res = 16'((m % 1024) * 2 + int'(s));
      end else begin
        res = 16'(e * 2048 + (m % 1024) * 2 + int'(s));
      end
    end
    lat = 1 + k;
  endfunction

  // Drive one item, wait (bounded) for out_valid; lat counts edges from accept.
  task automatic send(input logic s, input logic [4:0] e, input logic [11:0] m,
                      input logic n, input logic i, output int lat, output bit to);
    int w;
    to  = 1'b0;
    lat = 0;
    w   = 0;
    in_sign = s; in_exp = e; in_mant = m; in_nan = n; in_inf = i;
    in_valid = 1'b1;
    while (!in_ready && w < 20) begin
      @(posedge clkk); #1;
      w++;
    end
    @(posedge clkk); #1;
    in_valid = 1'b0;
    while (!out_valid && lat < 40) begin
      @(posedge clkk); #1;
      lat++;
    end
    if (!out_valid) to = 1'b1;
  endtask

  task automatic release_item();
    out_ready = 1'b1;
    @(posedge clkk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    checks++;
    if (out_valid !== 1'b0 || out_res !== 16'h0000 || out_overflow !== 1'b0 || out_underflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b res=%h ovf=%b unf=%b required 0 0000 0 0",
               out_valid, out_res, out_overflow, out_underflow);
    end
    @(posedge clkk); #1;
    rst = 1'b0;
    @(posedge clkk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_directed();
    vec_t vecs[16];
    int lat;
    bit to;
    vecs = '{
      '{1'b1, 5'd15, 12'h400, 1'b0, 1'b0, 16'h7801, 1'b0, 1'b0, 1},
      '{1'b0, 5'd15, 12'hC00, 1'b0, 1'b0, 16'h8400, 1'b0, 1'b0, 1},
      '{1'b0, 5'd15, 12'hC03, 1'b0, 1'b0, R_C03,    1'b0, 1'b0, 1},
      '{1'b0, 5'd15, 12'hC01, 1'b0, 1'b0, 16'h8400, 1'b0, 1'b0, 1},
      '{1'b0, 5'd15, 12'h100, 1'b0, 1'b0, 16'h6800, 1'b0, 1'b0, 3},
      '{1'b0, 5'd30, 12'h800, 1'b0, 1'b0, 16'hF800, 1'b1, 1'b0, 1},
      '{1'b0, 5'd2,  12'h040, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b1, 2},
      '{1'b1, 5'd7,  12'h123, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1},
      '{1'b1, 5'd10, 12'h400, 1'b0, 1'b1, 16'hF801, 1'b0, 1'b0, 1},
      '{1'b1, 5'd9,  12'h000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1},
      '{1'b0, 5'd0,  12'h200, 1'b0, 1'b0, 16'h0400, 1'b0, 1'b1, 1},
      '{1'b0, 5'd15, 12'hFFF, 1'b0, 1'b0, R_FFF,    1'b0, 1'b0, 1},
      '{1'b0, 5'd29, 12'hFFF, 1'b0, 1'b0, R_E29,    O_E29, 1'b0, 1},
      '{1'b0, 5'd15, 12'h001, 1'b0, 1'b0, 16'h2800, 1'b0, 1'b0, 11},
      '{1'b1, 5'd5,  12'h001, 1'b0, 1'b0, 16'h0021, 1'b0, 1'b1, 5},
      '{1'b0, 5'd3,  12'h000, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1}
    };
    foreach (vecs[v]) begin
      send(vecs[v].s, vecs[v].e, vecs[v].m, vecs[v].n, vecs[v].i, lat, to);
      checks++;
      if (to) begin
        errors++;
        $display("FAIL directed_timeout[%0d]: out_valid never rose within bound", v);
      end else if (out_res !== vecs[v].r || out_overflow !== vecs[v].ov ||
                   out_underflow !== vecs[v].un || lat != vecs[v].lat) begin
        errors++;
        $display("FAIL directed[%0d]: res=%h ovf=%b unf=%b lat=%0d required res=%h ovf=%b unf=%b lat=%0d",
                 v, out_res, out_overflow, out_underflow, lat,
                 vecs[v].r, vecs[v].ov, vecs[v].un, vecs[v].lat);
      end
      release_item();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_overflow !== 1'b0 || out_underflow !== 1'b0) begin
        errors++;
        $display("FAIL directed_release[%0d]: valid=%b ready=%b ovf=%b unf=%b required 0 1 0 0",
                 v, out_valid, in_ready, out_overflow, out_underflow);
      end
    end
  endtask

  // Items issued back to back: each accept one cycle after the prior handshake.
  task automatic test_back_to_back();
    logic        s, n, i;
    logic [4:0]  e;
    logic [11:0] m;
    logic [15:0] exp_res;
    logic        exp_ovf, exp_unf;
    int          exp_lat, lat;
    bit          to;
    for (int t = 0; t < 60; t++) begin
      s = 1'($urandom_range(0, 1));
      e = 5'($urandom_range(0, 30));
      m = 12'($urandom_range(0, 4095) >> $urandom_range(0, 11));
      n = ($urandom_range(0, 15) == 0);
      i = ($urandom_range(0, 15) == 0);
      model(s, int'(e), int'(m), n, i, exp_res, exp_ovf, exp_unf, exp_lat);
      send(s, e, m, n, i, lat, to);
      checks++;
      if (to) begin
        errors++;
        $display("FAIL random_timeout[%0d]: out_valid never rose within bound", t);
      end else if (out_res !== exp_res || out_overflow !== exp_ovf ||
                   out_underflow !== exp_unf || lat != exp_lat) begin
        errors++;
        $display("FAIL random[%0d] s=%b e=%0d m=%h n=%b i=%b: res=%h ovf=%b unf=%b lat=%0d required res=%h ovf=%b unf=%b lat=%0d",
                 t, s, e, m, n, i, out_res, out_overflow, out_underflow, lat,
                 exp_res, exp_ovf, exp_unf, exp_lat);
      end
      release_item();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL random_release[%0d]: valid=%b ready=%b required 0 1", t, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    bit to;
    bit bad;
    bad = 1'b0;
    send(1'b0, 5'd15, 12'h100, 1'b0, 1'b0, lat, to);
    // A competing upstream item must not be taken while the result waits.
    in_sign = 1'b1; in_exp = 5'd3; in_mant = 12'h7FF; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (out_valid !== 1'b1 || out_res !== 16'h6800 || in_ready !== 1'b0) begin
        bad = 1'b1;
        $display("FAIL backpressure_hold cycle %0d: valid=%b res=%h ready=%b required 1 6800 0",
                 c, out_valid, out_res, in_ready);
      end
      @(posedge clkk); #1;
    end
    checks++;
    if (to || bad) begin
      errors++;
      $display("FAIL backpressure: timeout=%b hold_error=%b required 0 0", to, bad);
    end
    in_valid = 1'b0;
    release_item();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_release: valid=%b ready=%b required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    bit to;
    bit seen;
    seen = 1'b0;
    in_sign = 1'b0; in_exp = 5'd15; in_mant = 12'h001; in_nan = 1'b0; in_inf = 1'b0;
    in_valid = 1'b1;
    @(posedge clkk); #1;
    in_valid = 1'b0;
    @(posedge clkk); #1;
    @(posedge clkk); #1;
    rst = 1'b1;
    #2;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_assert: valid=%b ready=%b required 0 1", out_valid, in_ready);
    end
    @(posedge clkk); #1;
    rst = 1'b0;
    for (int c = 0; c < 15; c++) begin
      if (out_valid !== 1'b0 || in_ready !== 1'b1) seen = 1'b1;
      @(posedge clkk); #1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL reset_mid_dropped: lost item reappeared or stage busy, seen=%b required 0", seen);
    end
    send(1'b1, 5'd15, 12'h400, 1'b0, 1'b0, lat, to);
    checks++;
    if (to || out_res !== 16'h7801 || lat != 1) begin
      errors++;
      $display("FAIL reset_mid_next: timeout=%b res=%h lat=%0d required 0 7801 1", to, out_res, lat);
    end
    release_item();
  endtask

  initial begin
    in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_mant = '0;
    in_nan = 1'b0; in_inf = 1'b0; out_ready = 1'b0; rst = 1'b1;
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule

// File: doc/fp_norm_pack.md
Name: fp_norm_pack

Overview:
- Post-add normalize-and-pack stage that sits directly downstream of the half-precision mantissa adder.
- Consumes the raw adder result: sign, biased exponent of the larger operand, and an unnormalized 12-bit mantissa (carry + hidden + fraction).
- Produces a normalized 16-bit result with overflow/underflow flags over a valid/ready handshake.
- Left normalization is iterative, one bit per cycle.

Parameters:
- EXP_W, 5, exponent field width; all-ones exponent = Inf/NaN.
- MAN_W, 10, fraction field width; in_mant is MAN_W+2 bits wide.

Ports:
- clkk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  upstream result valid
- in_ready  out  1  stage can accept (high only in IDLE)
- in_sign  in  1  result sign
- in_exp  in  EXP_W  biased exponent; 0 is treated as 1 with no hidden bit
- in_mant  in  MAN_W+2  bit MAN_W+1 = carry, bit MAN_W = hidden, rest = fraction
- in_nan  in  1  operand NaN detected upstream
- in_inf  in  1  operand Inf detected upstream
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_res  out  16  packed result: [15:11] exponent, [10:1] fraction, [0] sign
- out_overflow  out  1  result saturated to Inf
- out_underflow  out  1  result is subnormal (exponent field 0, nonzero fraction)

Behaviour:
- Reset (async): state IDLE; out_valid=0, out_res=0, out_overflow=0, out_underflow=0; in_ready=1 once rst releases. Reset mid-operation drops the item in flight.
- States: IDLE, NORM, DONE.
- IDLE: on in_valid&in_ready, register sign, exp (0 becomes 1), mant and flags; go to NORM.
- NORM, evaluated per edge in priority order:
  1. nan: out_res=0xFFFE (exponent all ones, fraction all ones, sign 0).
  2. inf: out_res={11111, 0, sign}.
  3. mant==0: out_res=0 with sign bit 0.
  4. Carry bit set: mant>>1, exp+1. If exp becomes 31, out_res={11111, 0, sign} and out_overflow=1.
  5. Hidden bit set: pack.
  6. Hidden bit clear and exp>1: mant<<1, exp-1, stay in NORM.
  7. Hidden bit clear and exp==1: pack with exponent field 0; out_underflow=1.
  - Every packing outcome goes to DONE with out_valid=1.
- Latency: out_valid rises at edge N+1+k, where N = accept edge and k = number of left shifts (0..MAN_W).
- DONE: out_res and flags held stable while out_ready=0. On out_valid&out_ready: out_valid=0 and flags clear at the next edge; go to IDLE. No overlap: next accept is one cycle later at the earliest.
- Flags are valid only while out_valid=1.
- Exponent arithmetic uses EXP_W+1 bits internally; no wrap-around.
- Without rounding, right-shifted bits truncate.

Optional Feature:
- Macro FPNORM_ROUND_EN.
- Defined: a carry right-shift keeps the shifted-out guard bit and rounds to nearest-even (increment if guard=1 and the new lsb=1).
  - If the increment sets the carry bit again, shift right once more and exp+1, with the same overflow check.
  - This is resolved within the same NORM edge; latency is unchanged.
- Undefined: truncation.

Test Plan:
- Normalized in: exp=15, mant=0x400, sign=1 -> out_res=0x7801, no flags, out_valid one edge after accept.
- Carry in: exp=15, mant=0xC00 -> out_res=0x8400; with mant=0xC03, out_res=0x8402 without the macro and 0x8404 with FPNORM_ROUND_EN; mant=0xC01 gives 0x8400 in both builds.
- Leading zeros: exp=15, mant=0x100 -> out_res=0x6800, out_valid at accept+3.
- Overflow: exp=30, mant=0x800 -> out_res=0xF800, out_overflow=1.
- Subnormal: exp=2, mant=0x040 -> out_res=0x0100, out_underflow=1.
- Specials and handshake:
  - in_nan=1 -> out_res=0xFFFE.
  - Hold out_ready=0 for 5 cycles -> out_res stable and in_ready=0 throughout.
  - Assert rst while in NORM -> out_valid=0 and in_ready=1 after reset release; item lost.
